// File: rtl/stoch_posterior_acc_pkg.sv
// Shared Bayesian inference types: FSM encoding, default widths and the
// bayesian_4_4_64_64 configuration types used by the posterior datapath.
package stoch_posterior_acc_pkg;

    localparam int N_CLASS_DEF = 4;
    localparam int N_OBS_DEF   = 4;
    localparam int CNT_W_DEF   = 8;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE = 2'd0;
    localparam fsm_state_t ST_RUN  = 2'd1;
    localparam fsm_state_t ST_DONE = 2'd2;

    // bayesian_4_4_64_64: 4 classes x 4 observations, 64-bit probability and prior vectors
    localparam int BAYES_N_CLASS = 4;
    localparam int BAYES_N_OBS   = 4;
    localparam int BAYES_PROB_W  = 64;
    localparam int BAYES_PRIOR_W = 64;

    typedef logic [BAYES_PROB_W-1:0]  bayes_prob_vec_t;
    typedef logic [BAYES_PRIOR_W-1:0] bayes_prior_vec_t;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] count;
        logic [1:0]           class_idx;
    } bayes_result_t;

endpackage

// File: rtl/stoch_class_counter.sv
// One hypothesis class: ANDs its likelihood bits (stochastic product) and
// accumulates the result in a saturating counter.
module stoch_class_counter
    import stoch_posterior_acc_pkg::*;
#(
    parameter int N_OBS = N_OBS_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [N_OBS-1:0] bits_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             hit;

    always_comb begin
        hit   = en_i & (&bits_i);
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/stoch_posterior_acc.sv
// Stochastic posterior accumulator: runs a sample window over per-class
// likelihood bitstreams, then holds the counts and their argmax for handshake.
module stoch_posterior_acc
    import stoch_posterior_acc_pkg::*;
#(
    parameter int N_CLASS = N_CLASS_DEF,
    parameter int N_OBS   = N_OBS_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    localparam int IDX_W  = (N_CLASS > 1) ? $clog2(N_CLASS) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic [CNT_W-1:0]           window_i,
    input  logic [N_CLASS*N_OBS-1:0]   probabit_i,
    output logic                       sample_en_o,
    output logic                       busy_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [N_CLASS*CNT_W-1:0]   count_o,
    output logic [IDX_W-1:0]           argmax_o
);

    fsm_state_t       state_q;
    fsm_state_t       state_d;
    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] rem_d;
    logic             clr;
    logic             run;
    logic [CNT_W-1:0] cnt [N_CLASS];
    logic [CNT_W-1:0] best_val;
    logic [IDX_W-1:0] best_idx;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    clr = 1'b1;
                    if (window_i != '0) begin
                        rem_d   = window_i;
                        state_d = ST_RUN;
                    end else begin
                        rem_d   = '0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // start_i is deliberately not looked at here, even on the handshake cycle
                if (ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    assign run         = (state_q == ST_RUN);
    assign sample_en_o = run;
    assign busy_o      = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign valid_o     = (state_q == ST_DONE);

    for (genvar c = 0; c < N_CLASS; c++) begin : g_class
        stoch_class_counter #(
            .N_OBS (N_OBS),
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clr_i  (clr),
            .en_i   (run),
            .bits_i (probabit_i[c*N_OBS +: N_OBS]),
            .cnt_o  (cnt[c])
        );
        assign count_o[c*CNT_W +: CNT_W] = cnt[c];
    end

    // Strict greater-than keeps the lowest index on ties
    always_comb begin
        best_val = cnt[0];
        best_idx = '0;
        for (int c = 1; c < N_CLASS; c++) begin
            if (cnt[c] > best_val) begin
                best_val = cnt[c];
                best_idx = IDX_W'(c);
            end
        end
    end

    assign argmax_o = best_idx;

endmodule

// File: tb/tb_stoch_posterior_acc.sv
// Directed bench for stoch_posterior_acc with a small upstream LFSR model.
module tb_stoch_posterior_acc;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        start_i = 1'b0;
    logic [7:0]  window_i = 8'd0;
    logic [15:0] prob_man = 16'h0000;
    logic [15:0] probabit_i;
    logic        sample_en_o;
    logic        busy_o;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] count_o;
    logic [1:0]  argmax_o;

    int errors = 0;
    int checks = 0;

    logic       use_lfsr = 1'b0;
    logic       lfsr_load = 1'b0;
    logic [7:0] lfsr [4];
    logic [15:0] lfsr_bits;

    localparam logic [7:0] PROBA [4] = '{8'h80, 8'h40, 8'h20, 8'h10};
    localparam logic [7:0] SEED  [4] = '{8'h5A, 8'hC3, 8'h17, 8'hE8};

    stoch_posterior_acc dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .window_i    (window_i),
        .probabit_i  (probabit_i),
        .sample_en_o (sample_en_o),
        .busy_o      (busy_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .count_o     (count_o),
        .argmax_o    (argmax_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
    endfunction

    // Upstream Gupta converters: class c obs 0 compares its LFSR against PROBA[c], obs 1..3 tied high
    always_comb begin
        lfsr_bits = 16'hFFFF;
        for (int c = 0; c < 4; c++) lfsr_bits[c*4] = (lfsr[c] < PROBA[c]);
    end

    assign probabit_i = use_lfsr ? lfsr_bits : prob_man;

    always @(posedge clk_i) begin
        for (int c = 0; c < 4; c++) begin
            if (lfsr_load) lfsr[c] <= SEED[c];
            else if (sample_en_o) lfsr[c] <= lfsr_step(lfsr[c]);
        end
    end

    // Releases start_i and waits for valid_o, counting sample_en_o cycles
    task automatic wait_done(input int limit, output int n_samp, output bit timed_out);
        n_samp = 0;
        timed_out = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (sample_en_o) n_samp++;
            if (valid_o) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk_i);
        end
    endtask

    task automatic test_reset();
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({sample_en_o, busy_o, valid_o} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: got %b want 000", {sample_en_o, busy_o, valid_o});
        end
        checks++;
        if (count_o !== 32'h0) begin
            errors++; $display("FAIL reset_counts: got %h want 00000000", count_o);
        end
        checks++;
        if (argmax_o !== 2'd0) begin
            errors++; $display("FAIL reset_argmax: got %0d want 0", argmax_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_window10();
        int n; bit to;
        prob_man = 16'hFFFF;
        start_i = 1'b1; window_i = 8'd10;
        wait_done(300, n, to);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL w10_timeout: got %0b want 0", to); end
        checks++;
        if (n != 10) begin errors++; $display("FAIL w10_samples: got %0d want 10", n); end
        checks++;
        if (count_o !== {4{8'd10}}) begin errors++; $display("FAIL w10_counts: got %h want 0a0a0a0a", count_o); end
        checks++;
        if (argmax_o !== 2'd0) begin errors++; $display("FAIL w10_argmax: got %0d want 0", argmax_o); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checks++;
            if ({valid_o, busy_o, sample_en_o} !== 3'b110) begin
                errors++; $display("FAIL w10_hold: got %b want 110", {valid_o, busy_o, sample_en_o});
            end
        end
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
        checks++;
        if ({valid_o, busy_o} !== 2'b00) begin errors++; $display("FAIL w10_accept: got %b want 00", {valid_o, busy_o}); end
        @(negedge clk_i);
        checks++;
        if (count_o !== {4{8'd10}}) begin errors++; $display("FAIL w10_retain: got %h want 0a0a0a0a", count_o); end
    endtask

    task automatic test_window255();
        int n; bit to;
        prob_man = 16'hEFEE;
        start_i = 1'b1; window_i = 8'd255;
        wait_done(600, n, to);
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL w255_timeout: got %0b want 0", to); end
        checks++;
        if (n != 255) begin errors++; $display("FAIL w255_samples: got %0d want 255", n); end
        checks++;
        if (count_o !== 32'h00FF0000) begin errors++; $display("FAIL w255_counts: got %h want 00ff0000", count_o); end
        checks++;
        if (argmax_o !== 2'd2) begin errors++; $display("FAIL w255_argmax: got %0d want 2", argmax_o); end
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_window0();
        int n; bit to;
        prob_man = 16'hFFFF;
        start_i = 1'b1; window_i = 8'd0;
        @(negedge clk_i);
        start_i = 1'b0;
        n = sample_en_o ? 1 : 0;
        checks++;
        if (valid_o !== 1'b1) begin errors++; $display("FAIL w0_valid: got %b want 1", valid_o); end
        checks++;
        if (n != 0) begin errors++; $display("FAIL w0_sample_en: got %0d want 0", n); end
        checks++;
        if (count_o !== 32'h0) begin errors++; $display("FAIL w0_counts: got %h want 00000000", count_o); end
        checks++;
        if (argmax_o !== 2'd0) begin errors++; $display("FAIL w0_argmax: got %0d want 0", argmax_o); end
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
        to = valid_o;
        checks++;
        if (to !== 1'b0) begin errors++; $display("FAIL w0_accept: got %b want 0", to); end
    endtask

    task automatic test_start_in_run();
        int n;
        bit seen;
        prob_man = 16'hFFFF;
        start_i = 1'b1; window_i = 8'd6;
        @(negedge clk_i);
        start_i = 1'b0;
        n = 0; seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 2) begin start_i = 1'b1; window_i = 8'd3; end
            if (i == 3) start_i = 1'b0;
            if (sample_en_o) n++;
            if (valid_o) begin seen = 1'b1; break; end
            @(negedge clk_i);
        end
        checks++;
        if (seen !== 1'b1) begin errors++; $display("FAIL sir_timeout: got %0b want 1", seen); end
        checks++;
        if (n != 6) begin errors++; $display("FAIL sir_samples: got %0d want 6", n); end
        checks++;
        if (count_o !== {4{8'd6}}) begin errors++; $display("FAIL sir_counts: got %h want 06060606", count_o); end
        // start_i on the handshake cycle must not launch a new window
        ready_i = 1'b1; start_i = 1'b1; window_i = 8'd5;
        @(negedge clk_i);
        ready_i = 1'b0; start_i = 1'b0;
        checks++;
        if ({busy_o, valid_o, sample_en_o} !== 3'b000) begin
            errors++; $display("FAIL hs_start: got %b want 000", {busy_o, valid_o, sample_en_o});
        end
        @(negedge clk_i);
        checks++;
        if ({busy_o, sample_en_o} !== 2'b00) begin errors++; $display("FAIL hs_start_after: got %b want 00", {busy_o, sample_en_o}); end
    endtask

    task automatic test_reset_mid_run();
        int bad;
        prob_man = 16'hF000;
        start_i = 1'b1; window_i = 8'd20;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int i = 1; i < 5; i++) @(negedge clk_i);
        checks++;
        if ({count_o[31:24], argmax_o} !== {8'd4, 2'd3}) begin
            errors++; $display("FAIL rmr_pre: got cnt3=%0d arg=%0d want cnt3=4 arg=3", count_o[31:24], argmax_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({sample_en_o, busy_o, valid_o, argmax_o} !== 5'b0) begin
            errors++; $display("FAIL rmr_ctrl: got %b want 00000", {sample_en_o, busy_o, valid_o, argmax_o});
        end
        checks++;
        if (count_o !== 32'h0) begin errors++; $display("FAIL rmr_counts: got %h want 00000000", count_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_i);
            if (valid_o || sample_en_o || busy_o) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rmr_post: got %0d active cycles want 0", bad); end
    endtask

    task automatic test_lfsr_window8();
        int n; bit to;
        logic [7:0] s [4];
        logic [7:0] exp_cnt [4];
        logic [31:0] exp_vec;
        logic [1:0] exp_arg;
        logic [7:0] best;
        for (int c = 0; c < 4; c++) begin s[c] = SEED[c]; exp_cnt[c] = 8'd0; end
        for (int t = 0; t < 8; t++) begin
            for (int c = 0; c < 4; c++) begin
                if (s[c] < PROBA[c]) exp_cnt[c] = exp_cnt[c] + 8'd1;
                s[c] = lfsr_step(s[c]);
            end
        end
        exp_vec = {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]};
        exp_arg = 2'd0; best = exp_cnt[0];
        for (int c = 1; c < 4; c++) if (exp_cnt[c] > best) begin best = exp_cnt[c]; exp_arg = 2'(c); end
        lfsr_load = 1'b1;
        @(negedge clk_i);
        lfsr_load = 1'b0; use_lfsr = 1'b1;
        start_i = 1'b1; window_i = 8'd8;
        wait_done(100, n, to);
        checks++;
        if (to !== 1'b0 || n != 8) begin errors++; $display("FAIL lfsr_samples: got %0d to=%0b want 8", n, to); end
        checks++;
        if (count_o !== exp_vec) begin errors++; $display("FAIL lfsr_counts: got %h want %h", count_o, exp_vec); end
        checks++;
        if (argmax_o !== exp_arg) begin errors++; $display("FAIL lfsr_argmax: got %0d want %0d", argmax_o, exp_arg); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            checks++;
            if ({valid_o, count_o, argmax_o} !== {1'b1, exp_vec, exp_arg}) begin
                errors++; $display("FAIL lfsr_stable: got v=%b %h %0d want v=1 %h %0d", valid_o, count_o, argmax_o, exp_vec, exp_arg);
            end
        end
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0; use_lfsr = 1'b0;
        checks++;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL lfsr_accept: got %b want 0", valid_o); end
    endtask

    initial begin
        test_reset();
        test_window10();
        test_window255();
        test_window0();
        test_start_in_run();
        test_reset_mid_run();
        test_lfsr_window8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
